// File: rtl/input_conditioner.sv
// Per-bit 2-flop sync, tick-sampled saturating debounce, and rise/fall edge pulses.
// Define INPUT_CONDITIONER_FALL_EN to drive the fall output; otherwise fall is tied low.
module input_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int SW = (SAMPLE_CNT_MAX > 0) ? $clog2(SAMPLE_CNT_MAX + 1) : 1;
  localparam int CW = (PULSE_CNT_MAX > 0) ? $clog2(PULSE_CNT_MAX + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(SAMPLE_CNT_MAX);
  localparam logic [CW-1:0] PMAX = CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [SW-1:0]    r_sample_cnt;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_level_q;
  logic             w_tick;
  logic [WIDTH-1:0] w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
    end
  end

  assign w_tick = (r_sample_cnt == SMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
    end else if (w_tick) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  // A single low synchronized sample discards all accumulated credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!r_s2[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick && (r_cnt[i] < PMAX)) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_level = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_level[i] = (r_cnt[i] == PMAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q <= '0;
    end else begin
      r_level_q <= w_level;
    end
  end

  assign level = w_level;
  assign rise  = w_level & ~r_level_q;

`ifdef INPUT_CONDITIONER_FALL_EN
  assign fall = ~w_level & r_level_q;
`else
  assign fall = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 5-cycle tick and 3-sample qualification.
module tb_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;

  int n_cmp = 0;
  int n_err = 0;

`ifdef INPUT_CONDITIONER_FALL_EN
  localparam logic FALL_EXP = 1'b1;
`else
  localparam logic FALL_EXP = 1'b0;
`endif

  input_conditioner #(
    .WIDTH         (4),
    .SAMPLE_CNT_MAX(4),
    .PULSE_CNT_MAX (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int bad;
    int pulses;

    rst_n = 1'b0;
    in    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_outputs", 32'({level, rise, fall}), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in    = 4'h0;
    step();
    check("rel_first_edge", 32'({level, rise, fall}), 32'h0);
    repeat (5) step();

    // Clean press on bit 0
    in[0] = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (level[0]) begin
        n = i;
        break;
      end
    end
    check("press_latency_13_17", 32'(n >= 13 && n <= 17), 32'd1);
    check("press_rise0", 32'(rise[0]), 32'd1);
    check("press_others_quiet", 32'({level[3:1], rise[3:1]}), 32'h0);
    step();
    check("press_rise_once", 32'(rise[0]), 32'd0);
    check("press_level_hold", 32'(level[0]), 32'd1);

    // Release: level drops on the third edge
    in[0] = 1'b0;
    step();
    check("rel_level_e1", 32'(level[0]), 32'd1);
    step();
    check("rel_level_e2", 32'(level[0]), 32'd1);
    step();
    check("rel_level_e3", 32'(level[0]), 32'd0);
    check("rel_no_rise", 32'(rise[0]), 32'd0);
    check("rel_fall", 32'(fall[0]), 32'(FALL_EXP));
    step();
    check("rel_fall_once", 32'(fall[0]), 32'd0);

    // Bounce on bit 1: 3 high / 3 low never qualifies
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      in[1] = ((i % 6) < 3);
      step();
      if (level[1] || rise[1]) bad++;
    end
    check("bounce_quiet_cycles", 32'(bad), 32'd0);
    in[1] = 1'b0;
    repeat (3) step();
    check("bounce_settled", 32'({level, rise, fall}), 32'h0);

    // Reset mid-count on bit 2
    in[2] = 1'b1;
    repeat (10) step();
    check("midrst_pre_level", 32'(level[2]), 32'd0);
    rst_n = 1'b0;
    step();
    check("midrst_outputs", 32'({level, rise, fall}), 32'h0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (level[2]) begin
        n = i;
        break;
      end
    end
    check("midrst_latency_13_17", 32'(n >= 13 && n <= 17), 32'd1);
    check("midrst_rise2", 32'(rise[2]), 32'd1);
    in = 4'h0;
    repeat (5) step();
    check("midrst_cleared", 32'(level), 32'h0);

    // Simultaneous press on bits 3 and 0
    in = 4'b1001;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (level != 4'h0) begin
        n = i;
        break;
      end
    end
    check("sim_found", 32'(n > 0), 32'd1);
    check("sim_level", 32'(level), 32'h9);
    check("sim_rise", 32'(rise), 32'h9);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      in = 4'b1001;
      step();
      if (rise != 4'h0) pulses++;
    end
    check("sim_no_repeat_pulse", 32'(pulses), 32'd0);
    check("sim_level_held", 32'(level), 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
